// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing stage: debounced request, WALK grant on RED entry, flashing clearance.
// Optional audible walk drive enabled by defining PED_BEEP_EN.
module ped_crossing_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 20,
    parameter int CLEAR_CYCLES    = 10,
    parameter int FLASH_HALF      = 2,
    parameter int BEEP_HALF       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       wait_lamp,
    output logic       beep
);
    localparam logic [2:0] RED_CODE = 3'b100;
    localparam int TMAX = (WALK_CYCLES > CLEAR_CYCLES) ? WALK_CYCLES : CLEAR_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int FW   = $clog2(FLASH_HALF) + 1;
    localparam logic [TW-1:0] WALK_LAST  = TW'(WALK_CYCLES - 1);
    localparam logic [TW-1:0] CLEAR_LAST = TW'(CLEAR_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WALK, S_CLEAR} state_t;

    state_t        state, nstate;
    logic [2:0]    prev_light;
    logic          red, red_entry;
    logic          sync1, sync2, stable, stable_d, press;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] timer;
    logic [FW-1:0] fcnt;
    logic          flash;

    assign red       = (light == RED_CODE);
    assign red_entry = red && (prev_light != RED_CODE);
    assign press     = stable && !stable_d;

    // Button path: 2-FF synchroniser, then a counter that must see DEBOUNCE_CYCLES
    // consecutive disagreements before the stable value follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            dcnt     <= '0;
        end else begin
            sync1    <= ped_btn;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                stable <= sync2;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prev_light <= RED_CODE;
            timer      <= '0;
            fcnt       <= '0;
            flash      <= 1'b1;
        end else begin
            state      <= nstate;
            prev_light <= light;
            if (nstate != state || (state != S_WALK && state != S_CLEAR))
                timer <= '0;
            else
                timer <= timer + 1'b1;
            if (nstate == S_CLEAR && state != S_CLEAR) begin
                flash <= 1'b1;
                fcnt  <= '0;
            end else if (state == S_CLEAR) begin
                if (fcnt == FLASH_LAST) begin
                    flash <= ~flash;
                    fcnt  <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (press) nstate = S_ARMED;
            S_ARMED: if (red_entry) nstate = S_WALK;
            S_WALK: begin
                if (!red)                   nstate = S_IDLE;
                else if (timer == WALK_LAST) nstate = S_CLEAR;
            end
            S_CLEAR: begin
                if (!red || timer == CLEAR_LAST) nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    // Leaving RED while in WALK/CLEAR forces the safe lamp state in the same cycle.
    always_comb begin
        walk      = 1'b0;
        dont_walk = 1'b1;
        wait_lamp = 1'b0;
        case (state)
            S_ARMED: wait_lamp = 1'b1;
            S_WALK: begin
                walk      = red;
                dont_walk = ~red;
            end
            S_CLEAR: dont_walk = red ? flash : 1'b1;
            default: ;
        endcase
    end

`ifdef PED_BEEP_EN
    localparam int BW = $clog2(BEEP_HALF) + 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_HALF - 1);
    logic [BW-1:0] bcnt;
    logic          beep_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt   <= '0;
            beep_q <= 1'b0;
        end else if (nstate == S_WALK && state != S_WALK) begin
            bcnt   <= '0;
            beep_q <= 1'b1;
        end else if (state == S_WALK) begin
            if (bcnt == BEEP_LAST) begin
                beep_q <= ~beep_q;
                bcnt   <= '0;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    assign beep = walk & beep_q;
`else
    assign beep = 1'b0;
`endif
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: reset, grant timing, bounce, safety abort,
// mid-RED request, reset mid-WALK and the optional beep output.
module tb_ped_crossing_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light;
    logic       ped_btn;
    logic       walk, dont_walk, wait_lamp, beep;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] L_RED = 3'b100, L_RA = 3'b110, L_GRN = 3'b001, L_AMB = 3'b010;

    ped_crossing_ctrl dut (
        .clk(clk), .rst(rst), .light(light), .ped_btn(ped_btn),
        .walk(walk), .dont_walk(dont_walk), .wait_lamp(wait_lamp), .beep(beep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [9:0] flash_pat;
        logic       exp_beep;
        flash_pat = 10'b1100110011;

        // 1. reset
        rst = 1'b1; light = L_RED; ped_btn = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("rst_walk", walk, 0);
        chk("rst_dw", dont_walk, 1);
        chk("rst_wait", wait_lamp, 0);
        chk("rst_beep", beep, 0);
        light = L_GRN; tick(2);
        light = L_RED; tick(3);
        chk("rst_nogrant_walk", walk, 0);
        chk("rst_nogrant_wait", wait_lamp, 0);

        // 2. press during GREEN, full grant
        light = L_GRN;
        ped_btn = 1'b1;
        tick(6);
        chk("press_lat6_wait", wait_lamp, 0);
        tick(1);
        chk("press_lat7_wait", wait_lamp, 1);
        tick(1);
        ped_btn = 1'b0;
        tick(10);
        chk("armed_hold_wait", wait_lamp, 1);
        chk("armed_dw", dont_walk, 1);
        light = L_AMB; tick(2);
        chk("amber_nowalk", walk, 0);
        light = L_RED; tick(1);
        for (int i = 0; i < 20; i++) begin
`ifdef PED_BEEP_EN
            exp_beep = (i % 2 == 0);
`else
            exp_beep = 1'b0;
`endif
            chk($sformatf("walk_c%0d", i), walk, 1);
            chk($sformatf("walk_dw_c%0d", i), dont_walk, 0);
            chk($sformatf("walk_beep_c%0d", i), beep, exp_beep);
            tick(1);
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("clear_walk_c%0d", i), walk, 0);
            chk($sformatf("clear_dw_c%0d", i), dont_walk, flash_pat[9-i]);
            chk($sformatf("clear_beep_c%0d", i), beep, 0);
            tick(1);
        end
        chk("post_idle_dw", dont_walk, 1);
        chk("post_idle_wait", wait_lamp, 0);
        chk("post_idle_walk", walk, 0);

        // 3. bounce: pulses of 1..3 cycles never reach the debounce threshold
        light = L_GRN;
        for (int w = 1; w <= 3; w++) begin
            ped_btn = 1'b1; tick(w);
            ped_btn = 1'b0; tick(1);
        end
        tick(8);
        chk("bounce_wait", wait_lamp, 0);
        ped_btn = 1'b1; tick(5);
        ped_btn = 1'b0; tick(10);
        chk("hold5_wait", wait_lamp, 1);

        // 4. safety abort at WALK cycle 7
        light = L_AMB; tick(1);
        light = L_RED; tick(1);
        chk("abort_walk_c0", walk, 1);
        tick(7);
        chk("abort_walk_c7", walk, 1);
        light = L_GRN;
        #1;
        chk("abort_gate_walk", walk, 0);
        chk("abort_gate_dw", dont_walk, 1);
        tick(1);
        chk("abort_idle_wait", wait_lamp, 0);
        chk("abort_idle_dw", dont_walk, 1);
        light = L_AMB; tick(1);
        light = L_RED; tick(3);
        chk("abort_noregrant", walk, 0);

        // 5. request accepted mid-RED waits for the next red entry
        tick(5);
        ped_btn = 1'b1; tick(7);
        ped_btn = 1'b0;
        chk("midred_wait", wait_lamp, 1);
        chk("midred_nowalk", walk, 0);
        tick(5);
        chk("midred_hold_walk", walk, 0);
        light = L_RA;  tick(3);
        chk("ra_armed", wait_lamp, 1);
        light = L_GRN; tick(3);
        chk("grn_armed", wait_lamp, 1);
        light = L_AMB; tick(3);
        chk("amb_armed", wait_lamp, 1);
        chk("amb_nowalk", walk, 0);
        light = L_RED; tick(1);
        chk("midred_grant", walk, 1);

        // reset mid-WALK discards the request
        tick(3);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        chk("rstwalk_walk", walk, 0);
        chk("rstwalk_dw", dont_walk, 1);
        chk("rstwalk_wait", wait_lamp, 0);
        light = L_AMB; tick(1);
        light = L_RED; tick(2);
        chk("rstwalk_noregrant", walk, 0);

        // illegal light code during WALK behaves as !red
        light = L_GRN;
        ped_btn = 1'b1; tick(8);
        ped_btn = 1'b0; tick(8);
        light = L_AMB; tick(1);
        light = L_RED; tick(2);
        chk("illegal_pre_walk", walk, 1);
        light = 3'b101;
        #1;
        chk("illegal_walk", walk, 0);
        chk("illegal_dw", dont_walk, 1);
        tick(1);
        light = L_RED;
        #1;
        chk("illegal_idle_walk", walk, 0);
        chk("illegal_idle_wait", wait_lamp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
